// File: rtl/regime_arbiter_pkg.sv
// Shared codes for the regime arbiter: controller mode codes, FSM states, requester indices.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regime_arbiter_pkg;

    localparam logic [1:0] MODE_OFF     = 2'd0;
    localparam logic [1:0] MODE_ENUM    = 2'd1;
    localparam logic [1:0] MODE_COUNT   = 2'd2;
    localparam logic [1:0] MODE_REFRESH = 2'd3;

    localparam int REQ_ENUM    = 0;
    localparam int REQ_COUNT   = 1;
    localparam int REQ_REFRESH = 2;
    localparam int NUM_REQ     = 3;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ENTER,
        RUN,
        WAIT_OFF,
        DONE
    } state_t;

    function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
        return oh[2] ? 2'd2 : (oh[1] ? 2'd1 : 2'd0);
    endfunction

    function automatic logic [1:0] next_ptr(input logic [1:0] idx);
        return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/regime_arbiter_picker.sv
// 3-way round-robin winner select with a refresh priority override.
// Latency: combinational.
// Backpressure: none; win is all-zero when nothing requests.
module rr_picker
    import regime_arbiter_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] rr_ptr,
    input  logic       force_refresh,
    output logic [2:0] win
);

    always_comb begin
        win = 3'b000;
        if (force_refresh && req[REQ_REFRESH]) begin
            win = 3'b100;
        end else begin
            case (rr_ptr)
                2'd1:    win = req[1] ? 3'b010 : (req[2] ? 3'b100 : (req[0] ? 3'b001 : 3'b000));
                2'd2:    win = req[2] ? 3'b100 : (req[0] ? 3'b001 : (req[1] ? 3'b010 : 3'b000));
                default: win = req[0] ? 3'b001 : (req[1] ? 3'b010 : (req[2] ? 3'b100 : 3'b000));
            endcase
        end
    end

endmodule

// File: rtl/regime_arbiter.sv
// Serialises enum/count/refresh runs onto the single regime controller, one run at a time.
// Latency: grant one cycle after a qualifying request in IDLE; done when the controller returns to off.
// Backpressure: requests wait while busy or while the controller is not off; watchdog aborts hung runs.
module regime_arbiter
    import regime_arbiter_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int REFRESH_MAX = 32,
    parameter int TIMEOUT     = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       req,
    input  logic [CNT_W-1:0] req_len,
    output logic [2:0]       grant,
    output logic [2:0]       done,
    output logic             busy,
    output logic             err,
    output logic [1:0]       on,
    output logic             start,
    input  logic [1:0]       regime,
    input  logic             active
);

    localparam int AGE_W = 8;
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    state_t           state;
    logic [1:0]       mode;
    logic [1:0]       rr_ptr;
    logic [AGE_W-1:0] age;
    logic [CNT_W-1:0] len;
    logic [CNT_W-1:0] run_cnt;
    logic [WD_W-1:0]  wdog;

    logic [2:0]       win;
    logic [1:0]       win_mode;
    logic             force_refresh;
    logic             grant_now;
    logic             wait_miss;
    logic             wd_fire;

    assign force_refresh = req[REQ_REFRESH] && (age >= AGE_W'(REFRESH_MAX));
    assign grant_now     = (state == IDLE) && (req != 3'b000) && (regime == MODE_OFF);
    assign win_mode      = onehot_to_idx(win) + 2'd1;
    assign wait_miss     = ((state == WAIT_ENTER) && (regime != mode)) ||
                           ((state == WAIT_OFF)   && (regime != MODE_OFF));
    assign wd_fire       = wait_miss && (wdog == WD_W'(TIMEOUT - 1));

    rr_picker u_picker (
        .req           (req),
        .rr_ptr        (rr_ptr),
        .force_refresh (force_refresh),
        .win           (win)
    );

    // Waiting time of a pending refresh; held at zero while refresh owns the controller.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            age <= '0;
        end else if (!req[REQ_REFRESH] || grant[REQ_REFRESH] || (grant_now && win[REQ_REFRESH])) begin
            age <= '0;
        end else if (age < AGE_W'(REFRESH_MAX)) begin
            age <= age + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            grant   <= 3'b000;
            done    <= 3'b000;
            busy    <= 1'b0;
            err     <= 1'b0;
            on      <= MODE_OFF;
            start   <= 1'b0;
            rr_ptr  <= 2'd0;
            mode    <= MODE_OFF;
            len     <= '0;
            run_cnt <= '0;
            wdog    <= '0;
        end else begin
            done <= 3'b000;
            if (wd_fire) begin
                // Abandon the run silently: no done pulse, pointer left where it was.
                err   <= 1'b1;
                on    <= MODE_OFF;
                start <= 1'b0;
                grant <= 3'b000;
                busy  <= 1'b0;
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (grant_now) begin
                            grant <= win;
                            mode  <= win_mode;
                            on    <= win_mode;
                            len   <= (req_len == '0) ? CNT_W'(1) : req_len;
                            busy  <= 1'b1;
                            state <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        on    <= MODE_OFF;
                        wdog  <= '0;
                        state <= WAIT_ENTER;
                    end
                    WAIT_ENTER: begin
                        if (regime == mode) begin
                            run_cnt <= CNT_W'(1);
                            start   <= (mode == MODE_ENUM) || (mode == MODE_COUNT);
                            state   <= RUN;
                        end else begin
                            wdog <= wdog + 1'b1;
                        end
                    end
                    RUN: begin
                        if ((mode == MODE_COUNT) && (run_cnt < len)) begin
                            run_cnt <= run_cnt + 1'b1;
                        end else begin
                            start <= 1'b0;
                            wdog  <= '0;
                            state <= WAIT_OFF;
                        end
                    end
                    WAIT_OFF: begin
                        if (regime == MODE_OFF) begin
                            done  <= grant;
                            state <= DONE;
                        end else begin
                            wdog <= wdog + 1'b1;
                        end
                    end
                    DONE: begin
                        grant  <= 3'b000;
                        busy   <= 1'b0;
                        rr_ptr <= next_ptr(onehot_to_idx(grant));
                        state  <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // The controller may only report enum-active while it is in the enum regime.
    a_active_enum: assert property (@(posedge clk) disable iff (rst) active |-> (regime == MODE_ENUM));
    a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
    a_done_granted: assert property (@(posedge clk) disable iff (rst) (done != 3'b000) |-> (done == grant));
    a_on_issue_only: assert property (@(posedge clk) disable iff (rst) (on != MODE_OFF) |-> (state == ISSUE));

endmodule

// File: doc/regime_arbiter.md
Name: regime_arbiter

Overview:
- Shares the single regime controller (on/start/regime/active interface) among three requesters: enumerate (mode 1), count (mode 2) and refresh (mode 3).
- Serialises one regime run at a time: issues the on code, drives start as the mode needs, waits for regime to return to 0, then pulses done to the winner.
- Round-robin arbitration with a refresh anti-starvation override and an entry/exit watchdog.
- Sits between the requesting logic and the regime controller's inputs.

Parameters:
- CNT_W, 8, width of the count-mode duration input req_len.
- REFRESH_MAX, 32, cycles a pending refresh may wait before it overrides round-robin (1..2^8-1).
- TIMEOUT, 64, watchdog limit in cycles for the WAIT_ENTER and WAIT_OFF phases.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- req  in  3  level requests; bit0 enum, bit1 count, bit2 refresh
- req_len  in  CNT_W  count-mode duration in cycles; sampled at grant; 0 treated as 1
- grant  out  3  one-hot; held from grant through the done cycle
- done  out  3  one-cycle pulse to the served requester
- busy  out  1  high whenever state != IDLE
- err  out  1  sticky watchdog flag; cleared only by rst
- on  out  2  regime request code to the controller; nonzero for exactly one cycle per run
- start  out  1  start/hold to the controller
- regime  in  2  controller's current regime (0 = off)
- active  in  1  controller enum-active flag

Behaviour:
- Interface fixed: one clock, clk; rst asynchronous, active-high.
- Reset values: on=0, start=0, grant=0, done=0, busy=0, err=0, rr_ptr=0, age=0, state=IDLE.

State machine: IDLE -> ISSUE -> WAIT_ENTER -> RUN -> WAIT_OFF -> DONE -> IDLE.
- IDLE: when req!=0 and regime==0, pick a winner, register grant and mode=index+1, latch len=max(req_len,1), go ISSUE.
- ISSUE: on=mode for one cycle; go WAIT_ENTER.
- WAIT_ENTER: on=0. When regime==mode, go RUN.
- RUN, enum: start=1 for exactly one cycle, then go WAIT_OFF. Controller runs 17 active cycles on its own.
- RUN, count: start=1 for len consecutive cycles, then start=0 and go WAIT_OFF.
- RUN, refresh: start=0; go WAIT_OFF immediately.
- WAIT_OFF: start=0. When regime==0, go DONE.
- DONE: done[winner]=1 for one cycle; grant drops on the next cycle; rr_ptr = winner+1 mod 3; go IDLE.

Arbitration:
- Round-robin search starts at rr_ptr.
- Override: if req[2] is set and age>=REFRESH_MAX, refresh wins.
- age increments each cycle req[2]=1 and refresh is not granted; it saturates at REFRESH_MAX and resets to 0 on refresh grant or when req[2]=0.

Request rules:
- req may drop before grant with no effect.
- Request changes after grant are ignored until DONE.
- A requester still asserting req in the DONE cycle is eligible again in the next IDLE, subject to rr_ptr.

Watchdog:
- A counter runs in WAIT_ENTER and WAIT_OFF and clears on each state entry.
- Reaching TIMEOUT sets err, forces on=0 and start=0, issues no done pulse, clears grant, and returns to IDLE.
- IDLE does not grant while regime!=0.

Other boundaries:
- rst mid-run returns all outputs to reset values immediately.
- active is used only in assertions (must be 1 only while regime==1).
- Simultaneous requests follow rr_ptr order.

Decomposition:
- Shared package holds:
  - mode codes: MODE_OFF=0, MODE_ENUM=1, MODE_COUNT=2, MODE_REFRESH=3
  - state encodings
  - the requester index constants.
- One natural sub-module: rr_picker, a combinational 3-way round-robin with a priority-override input. Returns the one-hot winner given req, rr_ptr and force_refresh.

Test Plan:
- Enum only: req=001 -> on=1 for 1 cycle, then start=1 for 1 cycle after regime=1. active high 17 cycles, regime=0, done[0] pulse. Total about 21 cycles.
- Count, req_len=5: req=010 -> start high exactly 5 cycles while regime=2, then regime=0 and done[1]. req_len=0 gives 1 cycle.
- All three requests held, rr_ptr=0 -> grant order 001, 010, 100, 001. Exactly one done per run, with busy low for one cycle between runs.
- Starvation, REFRESH_MAX=8: enum and count toggle constantly and refresh is held -> refresh is granted as soon as age reaches 8 and the current run finishes.
- Watchdog: controller model never enters the regime -> after 64 cycles err=1, grant=0, no done, back to IDLE.
- rst asserted mid-count -> on, start and grant are 0 asynchronously. After release, a new req=010 completes normally.
